// File: rtl/spi_pkg.sv
// Shared definitions for the byte-wide SPI master: word width and FSM states.
package spi_pkg;

  localparam int SPI_WORD_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    LOW,
    TRAIL,
    GAP
  } spi_master_state_t;

endpackage : spi_pkg

// File: rtl/sync2.sv
// Generic two-flop synchronizer for bringing asynchronous inputs into clk.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync2

// File: rtl/spi_master.sv
// Byte-wide SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// One byte is exchanged per accepted start; dout is valid from the done pulse.
// Optional build macro SPI_MASTER_MISO_SYNC_EN: route miso through a two-flop
// synchronizer before sampling (HALF_PERIOD must then be at least 4).
module spi_master
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 1000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [SPI_WORD_W-1:0] din,
  output logic                  busy,
  output logic                  done,
  output logic [SPI_WORD_W-1:0] dout,
  output logic                  sck,
  output logic                  ss,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF_PERIOD - 1);
  localparam int BIT_W = $clog2(SPI_WORD_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SPI_WORD_W - 1);

  spi_master_state_t state, state_next;

  logic [CNT_W-1:0]      cnt;
  logic                  tick;
  logic [BIT_W-1:0]      bit_cnt;
  logic [SPI_WORD_W-1:0] tx_shift;
  logic [SPI_WORD_W-1:0] rx_shift;
  logic                  miso_s;

`ifdef SPI_MASTER_MISO_SYNC_EN
  sync2 #(.W(1)) u_miso_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (miso),
    .q     (miso_s)
  );
`else
  assign miso_s = miso;
`endif

  // The MSB of the transmit shifter is the flop that drives the pin.
  assign mosi = tx_shift[SPI_WORD_W-1];

  assign tick = (cnt == CNT_MAX);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: every timed state lasts exactly one half-period.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = LEAD;
      LEAD:    if (tick)  state_next = HIGH;
      HIGH:    if (tick)  state_next = (bit_cnt == LAST_BIT) ? TRAIL : LOW;
      LOW:     if (tick)  state_next = HIGH;
      TRAIL:   if (tick)  state_next = GAP;
      GAP:     if (tick)  state_next = IDLE;
      default:            state_next = IDLE;
    endcase
  end

  // Half-period counter; restarts from zero whenever the state changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == IDLE || state_next != state) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered SPI pins, shifters and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss       <= 1'b1;
      sck      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dout     <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
    end else begin
      // NOTE: non-blocking everywhere here; done is a pulse, so it defaults low each cycle.
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            tx_shift <= din;
            bit_cnt  <= '0;
            ss       <= 1'b0;
            busy     <= 1'b1;
          end
        end
        LEAD, LOW: begin
          // miso is captured on the same edge that raises sck.
          if (tick) begin
            sck      <= 1'b1;
            rx_shift <= {rx_shift[SPI_WORD_W-2:0], miso_s};
          end
        end
        HIGH: begin
          if (tick) begin
            sck <= 1'b0;
            if (bit_cnt != LAST_BIT) begin
              bit_cnt  <= bit_cnt + 1'b1;
              tx_shift <= tx_shift << 1;
            end
          end
        end
        TRAIL: begin
          if (tick) begin
            ss   <= 1'b1;
            dout <= rx_shift;
            done <= 1'b1;
          end
        end
        GAP: begin
          if (tick) busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule : spi_master
